// File: rtl/mem_ctrl_pkg.sv
// Shared types and address decode for the cpu memory controller.
//   state_e   : controller FSM states
//   region_e  : decoded target of a bus request
//   req_t     : latched bus request payload
//   region_of : address -> region decode
package mem_ctrl_pkg;

  localparam logic [3:0] MMIO_TOP_DEF = 4'hF;
  localparam int unsigned BUS_W = 32;
  localparam int unsigned MASK_W = BUS_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM,
    ST_MMIO,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_MMIO,
    RGN_UNMAPPED
  } region_e;

  typedef struct packed {
    logic [BUS_W-1:0]  addr;
    logic [BUS_W-1:0]  wdata;
    logic [MASK_W-1:0] wmask;
    logic              we;
  } req_t;

  // MMIO window has priority; RAM is the low 2**(ram_aw+2) bytes.
  function automatic region_e region_of(input logic [BUS_W-1:0] addr,
                                        input int unsigned      ram_aw,
                                        input logic [3:0]       mmio_top = MMIO_TOP_DEF);
    region_e r;
    if (addr[31:28] == mmio_top) begin
      r = RGN_MMIO;
    end else if ((addr >> (ram_aw + 32'd2)) == 32'd0) begin
      r = RGN_RAM;
    end else begin
      r = RGN_UNMAPPED;
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_bytewise.sv
// Single-port block RAM, 32-bit words, synchronous read, per-byte write enables.
//   clk   : clock
//   en    : read enable (rdata updates at the edge when high)
//   we    : byte write enables, lane b writes wdata[8b+7:8b]
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
module bram_bytewise
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_AW    = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic [MASK_W-1:0] we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [BUS_W-1:0]  wdata,
  output logic [BUS_W-1:0]  rdata
);

  localparam int unsigned DEPTH = 2 ** RAM_AW;

  logic [BUS_W-1:0] mem_q [DEPTH];
  logic [BUS_W-1:0] rdata_q;

  // Byte-lane writes and registered read; contents are never touched by reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(MASK_W); b++) begin
      if (we[b]) begin
        mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (en) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_mem_ctrl.sv
// Bus target for the multicycle cpu: decodes each request to block RAM, an
// external MMIO handshake port, or unmapped space, and returns rdata/done.
//   clk, rst            : clock, synchronous active-low reset
//   bus_addr/wdata/wmask/wen/ren : cpu request
//   bus_rdata, bus_done : registered read data, one-cycle completion pulse
//   mmio_req/we/addr/wdata/wmask : MMIO request, held until ack or timeout
//   mmio_rdata, mmio_ack: MMIO response
//   bus_err             : sticky flag for unmapped access or MMIO timeout
module cpu_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_AW    = 12,
  parameter logic [3:0]  MMIO_TOP  = MMIO_TOP_DEF,
  parameter int unsigned TIMEOUT   = 255,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_W-1:0]  bus_addr,
  input  logic [BUS_W-1:0]  bus_wdata,
  input  logic [MASK_W-1:0] bus_wmask,
  input  logic              bus_wen,
  input  logic              bus_ren,
  output logic [BUS_W-1:0]  bus_rdata,
  output logic              bus_done,
  output logic              mmio_req,
  output logic              mmio_we,
  output logic [BUS_W-1:0]  mmio_addr,
  output logic [BUS_W-1:0]  mmio_wdata,
  output logic [MASK_W-1:0] mmio_wmask,
  input  logic [BUS_W-1:0]  mmio_rdata,
  input  logic              mmio_ack,
  output logic              bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [BUS_W-1:0]  rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              mmio_req_q, mmio_req_d;
  logic              mmio_we_q, mmio_we_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ram_en;
  logic [MASK_W-1:0] ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [BUS_W-1:0]  ram_rdata;
  logic              bus_req;

  assign bus_req = bus_wen | bus_ren;

  // The RAM read is launched at acceptance so its word is ready to be
  // registered into bus_rdata at the edge leaving ST_RAM; writes land there.
  always_comb begin
    ram_en   = (state_q == ST_IDLE) && bus_req;
    ram_addr = (state_q == ST_IDLE) ? bus_addr[RAM_AW+1:2] : req_q.addr[RAM_AW+1:2];
    ram_we   = ((state_q == ST_RAM) && req_q.we) ? req_q.wmask : '0;
  end

  bram_bytewise #(
    .RAM_AW    (RAM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_bram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_q.wdata),
    .rdata (ram_rdata)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          req_d.addr  = bus_addr;
          req_d.wdata = bus_wdata;
          req_d.wmask = bus_wmask;
          req_d.we    = bus_wen;
          cnt_d       = '0;
          unique case (region_of(bus_addr, RAM_AW, MMIO_TOP))
            RGN_RAM:  state_d = ST_RAM;
            RGN_MMIO: state_d = ST_MMIO;
            default: begin
              state_d = ST_DONE;
              err_d   = 1'b1;
              if (!bus_wen) begin
                rdata_d = '0;
              end
            end
          endcase
        end
      end
      ST_RAM: begin
        state_d = ST_DONE;
        if (!req_q.we) begin
          rdata_d = ram_rdata;
        end
      end
      ST_MMIO: begin
        // Ack on the last counted cycle takes priority over the timeout.
        if (mmio_ack) begin
          state_d = ST_DONE;
          if (!req_q.we) begin
            rdata_d = mmio_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d     = (state_d == ST_DONE);
    mmio_req_d = (state_d == ST_MMIO);
    mmio_we_d  = (state_d == ST_MMIO) && req_d.we;
  end

  // State and output registers; reset leaves RAM contents alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      mmio_req_q <= 1'b0;
      mmio_we_q  <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      mmio_req_q <= mmio_req_d;
      mmio_we_q  <= mmio_we_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_done   = done_q;
  assign mmio_req   = mmio_req_q;
  assign mmio_we    = mmio_we_q;
  assign mmio_addr  = req_q.addr;
  assign mmio_wdata = req_q.wdata;
  assign mmio_wmask = req_q.wmask;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Scoreboard bench for cpu_mem_ctrl: stimulus pushes hand-computed expected
// completions; a negedge monitor pops and checks on every bus_done.
module tb_cpu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wmask;
  logic        bus_wen, bus_ren, bus_done;
  logic        mmio_req, mmio_we, mmio_ack, bus_err;
  logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;
  logic [3:0]  mmio_wmask;

  cpu_mem_ctrl #(
    .RAM_AW    (12),
    .MMIO_TOP  (4'hF),
    .TIMEOUT   (8),
    .INIT_FILE ("")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wmask  (bus_wmask),
    .bus_wen    (bus_wen),
    .bus_ren    (bus_ren),
    .bus_rdata  (bus_rdata),
    .bus_done   (bus_done),
    .mmio_req   (mmio_req),
    .mmio_we    (mmio_we),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_wmask (mmio_wmask),
    .mmio_rdata (mmio_rdata),
    .mmio_ack   (mmio_ack),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && bus_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL done_unexpected: got bus_done=1 with nothing outstanding, required 0");
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_rdata"}, bus_rdata, e.rd);
        chk({e.name, "_err"}, 32'(bus_err), 32'(e.err));
        chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Issue one request, act as MMIO responder, wait (bounded) for done.
  task automatic send(input string name, input logic wen, input logic ren,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm,
                      input int ack_after, input logic [31:0] ack_data,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                      output int req_cyc, output logic [31:0] m_addr, output logic m_we,
                      output logic [31:0] m_wdata, output logic [3:0] m_wmask);
    exp_t e;
    bit   got;
    @(negedge clk);
    bus_wen   = wen;
    bus_ren   = ren;
    bus_addr  = addr;
    bus_wdata = wd;
    bus_wmask = wm;
    e.name = name; e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat; e.acc = cyc;
    sb_q.push_back(e);
    req_cyc = 0; got = 1'b0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0; m_wmask = '0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      bus_wen  = 1'b0;
      bus_ren  = 1'b0;
      mmio_ack = 1'b0;
      if (bus_done) begin
        got = 1'b1;
      end else if (mmio_req) begin
        if (req_cyc == 0) begin
          m_addr = mmio_addr; m_we = mmio_we; m_wdata = mmio_wdata; m_wmask = mmio_wmask;
        end
        req_cyc++;
        if (ack_after > 0 && req_cyc == ack_after) begin
          mmio_ack   = 1'b1;
          mmio_rdata = ack_data;
        end
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_done_wait: got no bus_done within 40 cycles, required one", name);
    end
  endtask

  int          rc;
  logic [31:0] ma, mwd;
  logic        mwe;
  logic [3:0]  mwm;

  initial begin
    rst = 1'b0; bus_addr = '0; bus_wdata = '0; bus_wmask = '0;
    bus_wen = 1'b0; bus_ren = 1'b0; mmio_ack = 1'b0; mmio_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_done", 32'(bus_done), 32'd0);
    chk("reset_mmio_req", 32'(mmio_req), 32'd0);
    chk("reset_mmio_we", 32'(mmio_we), 32'd0);
    chk("reset_err", 32'(bus_err), 32'd0);
    chk("reset_rdata", bus_rdata, 32'h0);
    rst = 1'b1;

    // RAM word write/read, 2-cycle latency.
    send("wr_word", 1, 0, 32'h0000_0010, 32'hCAFE_BABE, 4'hF, 0, 0, 32'h0, 0, 2, rc, ma, mwe, mwd, mwm);
    send("rd_word", 0, 1, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'hCAFE_BABE, 0, 2, rc, ma, mwe, mwd, mwm);
    // Byte masks; writes leave bus_rdata alone.
    send("wr_base", 1, 0, 32'h0000_0010, 32'h1122_3344, 4'hF, 0, 0, 32'hCAFE_BABE, 0, 2, rc, ma, mwe, mwd, mwm);
    send("wr_byte0", 1, 0, 32'h0000_0010, 32'h0000_00AA, 4'b0001, 0, 0, 32'hCAFE_BABE, 0, 2, rc, ma, mwe, mwd, mwm);
    send("rd_byte0", 0, 1, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'h1122_33AA, 0, 2, rc, ma, mwe, mwd, mwm);
    send("wr_base2", 1, 0, 32'h0000_0014, 32'h5566_7788, 4'hF, 0, 0, 32'h1122_33AA, 0, 2, rc, ma, mwe, mwd, mwm);
    send("wr_mask_a", 1, 0, 32'h0000_0014, 32'hAABB_CCDD, 4'b1010, 0, 0, 32'h1122_33AA, 0, 2, rc, ma, mwe, mwd, mwm);
    // Low address bits are ignored for RAM.
    send("rd_mask_a", 0, 1, 32'h0000_0017, 32'h0, 4'h0, 0, 0, 32'hAA66_CC88, 0, 2, rc, ma, mwe, mwd, mwm);
    // wen and ren together is a write.
    send("wr_both", 1, 1, 32'h0000_0020, 32'h0000_0077, 4'hF, 0, 0, 32'hAA66_CC88, 0, 2, rc, ma, mwe, mwd, mwm);
    send("rd_both", 0, 1, 32'h0000_0020, 32'h0, 4'h0, 0, 0, 32'h0000_0077, 0, 2, rc, ma, mwe, mwd, mwm);
    // Last RAM word and word 0.
    send("wr_top", 1, 0, 32'h0000_3FFC, 32'h5EED_0001, 4'hF, 0, 0, 32'h0000_0077, 0, 2, rc, ma, mwe, mwd, mwm);
    send("rd_top", 0, 1, 32'h0000_3FFC, 32'h0, 4'h0, 0, 0, 32'h5EED_0001, 0, 2, rc, ma, mwe, mwd, mwm);
    send("wr_zero", 1, 0, 32'h0000_0000, 32'h0102_0304, 4'hF, 0, 0, 32'h5EED_0001, 0, 2, rc, ma, mwe, mwd, mwm);

    // MMIO read, ack in the 5th request cycle: done at acceptance+6.
    send("mmio_rd", 0, 1, 32'hF000_0004, 32'h0, 4'h0, 5, 32'h1234_5678, 32'h1234_5678, 0, 6, rc, ma, mwe, mwd, mwm);
    chk("mmio_rd_req_cycles", 32'(rc), 32'd5);
    chk("mmio_rd_addr", ma, 32'hF000_0004);
    chk("mmio_rd_we", 32'(mwe), 32'd0);
    // MMIO write: ack data ignored, rdata unchanged.
    send("mmio_wr", 1, 0, 32'hF000_0100, 32'hDEAD_BEEF, 4'b0011, 2, 32'hFFFF_FFFF, 32'h1234_5678, 0, 3, rc, ma, mwe, mwd, mwm);
    chk("mmio_wr_req_cycles", 32'(rc), 32'd2);
    chk("mmio_wr_we", 32'(mwe), 32'd1);
    chk("mmio_wr_wdata", mwd, 32'hDEAD_BEEF);
    chk("mmio_wr_wmask", 32'(mwm), 32'h3);
    // Timeout after 8 MMIO cycles.
    send("mmio_to", 0, 1, 32'hF000_0008, 32'h0, 4'h0, 0, 0, 32'h0, 1, 9, rc, ma, mwe, mwd, mwm);
    chk("mmio_to_req_cycles", 32'(rc), 32'd8);
    // Ack on the final counted cycle beats the timeout; err stays sticky.
    send("mmio_last", 0, 1, 32'hF000_000C, 32'h0, 4'h0, 8, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 9, rc, ma, mwe, mwd, mwm);
    chk("mmio_last_req_cycles", 32'(rc), 32'd8);

    // Unmapped: IDLE goes straight to DONE, so done follows acceptance by one cycle.
    send("unm_rd", 0, 1, 32'h4000_0000, 32'h0, 4'h0, 0, 0, 32'h0, 1, 1, rc, ma, mwe, mwd, mwm);
    send("rd_after_unm", 0, 1, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'h1122_33AA, 1, 2, rc, ma, mwe, mwd, mwm);
    send("unm_wr", 1, 0, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h1122_33AA, 1, 1, rc, ma, mwe, mwd, mwm);
    send("rd_zero", 0, 1, 32'h0000_0000, 32'h0, 4'h0, 0, 0, 32'h0102_0304, 1, 2, rc, ma, mwe, mwd, mwm);

    // Reset in the middle of an MMIO access: aborted, no done.
    @(negedge clk);
    bus_ren = 1'b1; bus_addr = 32'hF000_0010;
    @(negedge clk);
    bus_ren = 1'b0;
    chk("rstmid_req_before", 32'(mmio_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_req_after", 32'(mmio_req), 32'd0);
    chk("rstmid_done", 32'(bus_done), 32'd0);
    chk("rstmid_err", 32'(bus_err), 32'd0);
    chk("rstmid_rdata", bus_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_done_late", 32'(bus_done), 32'd0);
    send("rd_after_rst", 0, 1, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'h1122_33AA, 0, 2, rc, ma, mwe, mwd, mwm);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000, required finish");
    $fatal(1, "watchdog");
  end

endmodule
